// File: rtl/hazard_pkg.sv
// Shared sizing and countdown encodings for the ID-stage hazard scoreboard.
package hazard_pkg;
   localparam int NUM_REGS   = 16;
   localparam int REG_W      = 4;
   localparam int PIPE_DEPTH = 3;
   localparam int CNT_W      = 16;

   typedef logic [1:0] sb_cnt_t;

   // Countdown value tells which stage currently holds the producer.
   localparam sb_cnt_t CNT_EXE  = sb_cnt_t'(PIPE_DEPTH);
   localparam sb_cnt_t CNT_MEM  = 2'd2;
   localparam sb_cnt_t CNT_WB   = 2'd1;
   localparam sb_cnt_t CNT_IDLE = 2'd0;
endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One register's in-flight countdown and load flag; reports whether it blocks a reader.
// FORWARDING_EN selects load-use-only blocking; otherwise any EXE/MEM producer blocks.
module sb_entry
   import hazard_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic set,
   input  logic set_ld,
   output logic pending,
   output logic blocking
);

   sb_cnt_t cnt;

   // A new producer overwrites whatever is still counting down.
   always_ff @(posedge clk) begin
      if (rst)                   cnt <= CNT_IDLE;
      else if (set)              cnt <= CNT_EXE;
      else if (cnt != CNT_IDLE)  cnt <= cnt - sb_cnt_t'(1);
   end

   assign pending = (cnt != CNT_IDLE);

`ifdef FORWARDING_EN
   logic ld;

   always_ff @(posedge clk) begin
      if (rst)      ld <= 1'b0;
      else if (set) ld <= set_ld;
   end

   // MEM/WB forwarding covers everything except a load still in EXE.
   assign blocking = (cnt == CNT_EXE) && ld;
`else
   logic unused_set_ld;
   assign unused_set_ld = set_ld;

   // WB writes the register file mid-cycle, so only EXE/MEM producers block.
   assign blocking = (cnt >= CNT_MEM);
`endif

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: per-register countdown entries, source match, stall counter.
// Build with FORWARDING_EN defined to stall only on load-use.
module hazard_scoreboard
   import hazard_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [REG_W-1:0]    id_src1,
   input  logic [REG_W-1:0]    id_src2,
   input  logic                id_src2_used,
   input  logic [REG_W-1:0]    id_dest,
   input  logic                id_wb_en,
   input  logic                id_mem_r_en,
   input  logic                flush,
   output logic                hazard,
   output logic [NUM_REGS-1:0] pending_mask,
   output logic [CNT_W-1:0]    stall_count
);

   logic [NUM_REGS-1:0] set_vec;
   logic [NUM_REGS-1:0] block_vec;
   logic                issue;

   assign issue = id_valid & ~hazard & ~flush;

   always_comb begin
      set_vec = '0;
      if (issue && id_wb_en) set_vec[id_dest] = 1'b1;
   end

   for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
      sb_entry u_entry (
         .clk      (clk),
         .rst      (rst),
         .set      (set_vec[r]),
         .set_ld   (id_mem_r_en),
         .pending  (pending_mask[r]),
         .blocking (block_vec[r])
      );
   end

   assign hazard = id_valid & (block_vec[id_src1] | (id_src2_used & block_vec[id_src2]));

   // Flushed cycles are not real stalls; counter saturates instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst)
         stall_count <= '0;
      else if (hazard && !flush && !(&stall_count))
         stall_count <= stall_count + CNT_W'(1);
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scoreboard bench for hazard_scoreboard; expectations follow the FORWARDING_EN build.
`timescale 1ns/1ps
`ifdef FORWARDING_EN
`define SEL(nf, fw) (fw)
`else
`define SEL(nf, fw) (nf)
`endif

module tb_hazard_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [3:0]  id_src1;
   logic [3:0]  id_src2;
   logic        id_src2_used;
   logic [3:0]  id_dest;
   logic        id_wb_en;
   logic        id_mem_r_en;
   logic        flush;
   logic        hazard;
   logic [15:0] pending_mask;
   logic [15:0] stall_count;

   typedef struct {
      string       name;
      logic        haz;
      logic [15:0] mask;
      logic [15:0] stall;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   hazard_scoreboard dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_src1      (id_src1),
      .id_src2      (id_src2),
      .id_src2_used (id_src2_used),
      .id_dest      (id_dest),
      .id_wb_en     (id_wb_en),
      .id_mem_r_en  (id_mem_r_en),
      .flush        (flush),
      .hazard       (hazard),
      .pending_mask (pending_mask),
      .stall_count  (stall_count)
   );

   // Monitor: outputs are valid every cycle, sampled on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if (hazard !== e.haz) begin
               errors++;
               $display("FAIL %s hazard: got %0b expected %0b", e.name, hazard, e.haz);
            end
            checks++;
            if (pending_mask !== e.mask) begin
               errors++;
               $display("FAIL %s pending_mask: got %h expected %h", e.name, pending_mask, e.mask);
            end
            checks++;
            if (stall_count !== e.stall) begin
               errors++;
               $display("FAIL %s stall_count: got %0d expected %0d", e.name, stall_count, e.stall);
            end
         end
      end
   end

   task automatic step(input string nm, input logic v, input logic [3:0] s1, input logic [3:0] s2,
                       input logic s2u, input logic [3:0] d, input logic wb, input logic ld,
                       input logic fl, input logic r, input logic eh, input logic [15:0] em,
                       input logic [15:0] es);
      exp_t x;
      id_valid = v; id_src1 = s1; id_src2 = s2; id_src2_used = s2u;
      id_dest = d; id_wb_en = wb; id_mem_r_en = ld; flush = fl; rst = r;
      x.name = nm; x.haz = eh; x.mask = em; x.stall = es;
      q.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input string nm, input logic [15:0] em, input logic [15:0] es);
      step(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, em, es);
   endtask

   initial begin
      rst = 1'b1; id_valid = 0; id_src1 = 0; id_src2 = 0; id_src2_used = 0;
      id_dest = 0; id_wb_en = 0; id_mem_r_en = 0; flush = 0;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 5; i++) idle("reset_idle", 16'h0000, 16'd0);

      // ALU producer R1 followed by a reader of R1
      step("alu_r1",     1, 5, 6, 1, 1, 1, 0, 0, 0, 1'b0, 16'h0000, 16'd0);
      step("raw_r1_exe", 1, 1, 2, 1, 0, 0, 0, 0, 0, `SEL(1'b1, 1'b0), 16'h0002, 16'd0);
      step("raw_r1_mem", 1, 1, 2, 1, 0, 0, 0, 0, 0, `SEL(1'b1, 1'b0), 16'h0002, `SEL(16'd1, 16'd0));
      step("raw_r1_wb",  1, 1, 2, 1, 0, 0, 0, 0, 0, 1'b0, 16'h0002, `SEL(16'd2, 16'd0));
      idle("drain1", 16'h0000, `SEL(16'd2, 16'd0));

      // Load R2 consumed through src2
      step("ldr_r2",     1, 3, 4, 1, 2, 1, 1, 0, 0, 1'b0, 16'h0000, `SEL(16'd2, 16'd0));
      step("use_r2_exe", 1, 5, 2, 1, 0, 0, 0, 0, 0, 1'b1, 16'h0004, `SEL(16'd2, 16'd0));
      step("use_r2_mem", 1, 5, 2, 1, 0, 0, 0, 0, 0, `SEL(1'b1, 1'b0), 16'h0004, `SEL(16'd3, 16'd1));
      step("use_r2_wb",  1, 5, 2, 1, 0, 0, 0, 0, 0, 1'b0, 16'h0004, `SEL(16'd4, 16'd1));
      idle("drain2", 16'h0000, `SEL(16'd4, 16'd1));

      // src2 field names R2 but is not read; invalid ID never stalls
      step("ldr_r2_b",    1, 3, 4, 1, 2, 1, 1, 0, 0, 1'b0, 16'h0000, `SEL(16'd4, 16'd1));
      step("src2_unused", 1, 6, 2, 0, 0, 0, 0, 0, 0, 1'b0, 16'h0004, `SEL(16'd4, 16'd1));
      step("invalid_id",  0, 2, 2, 1, 0, 0, 0, 0, 0, 1'b0, 16'h0004, `SEL(16'd4, 16'd1));
      idle("wait_wb3", 16'h0004, `SEL(16'd4, 16'd1));
      idle("drain3",   16'h0000, `SEL(16'd4, 16'd1));

      // Load R3, dependent instruction squashed by flush
      step("ldr_r3",    1, 0, 0, 0, 3, 1, 1, 0, 0, 1'b0, 16'h0000, `SEL(16'd4, 16'd1));
      step("flush_exe", 1, 3, 0, 0, 9, 1, 0, 1, 0, 1'b1, 16'h0008, `SEL(16'd4, 16'd1));
      step("flush_mem", 1, 3, 0, 0, 9, 1, 0, 1, 0, `SEL(1'b1, 1'b0), 16'h0008, `SEL(16'd4, 16'd1));
      idle("ld_r3_wb", 16'h0008, `SEL(16'd4, 16'd1));
      idle("r3_clear", 16'h0000, `SEL(16'd4, 16'd1));

      // R4 ALU then R4 load back to back; reset while in flight
      step("alu_r4",     1, 0, 0, 0, 4, 1, 0, 0, 0, 1'b0, 16'h0000, `SEL(16'd4, 16'd1));
      step("ldr_r4",     1, 5, 6, 1, 4, 1, 1, 0, 0, 1'b0, 16'h0010, `SEL(16'd4, 16'd1));
      step("use_r4",     1, 4, 0, 0, 0, 0, 0, 0, 0, 1'b1, 16'h0010, `SEL(16'd4, 16'd1));
      step("rst_r4_mem", 1, 4, 0, 0, 8, 1, 0, 0, 1, `SEL(1'b1, 1'b0), 16'h0010, `SEL(16'd5, 16'd2));
      idle("post_rst", 16'h0000, 16'd0);
      step("use_r4_post", 1, 4, 0, 0, 0, 0, 0, 0, 0, 1'b0, 16'h0000, 16'd0);
      step("rst_issue",   1, 5, 0, 0, 8, 1, 0, 0, 1, 1'b0, 16'h0000, 16'd0);
      idle("post_rst2", 16'h0000, 16'd0);
      step("use_r8_post", 1, 8, 0, 0, 0, 0, 0, 0, 0, 1'b0, 16'h0000, 16'd0);

      for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations never checked, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
